regfile_wp_sched: RTL and testbench
===================================

# regfile_wp_sched

Write-port scheduler for the 32x32 MIPS register file (three-port: A1/A2/RD1/RD2 read, A3/WD3/WE3 write). It owns the single write port. After reset, or on request, it clears every register to zero, then shares the port between two writeback requesters (0 = ALU writeback, 1 = load writeback) with a valid/ready handshake and round-robin priority. It sits between the pipeline writeback stage and the register file write inputs. The read ports are not touched.

## Interface
- AW, 5, register address width
- DW, 32, data width
- NREG, 32, registers cleared by init sequence (2**AW)
- DROP_ZERO, 1, 1 = writes to address 0 are accepted but not issued (MIPS $zero)
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- CLR  in  1  request a full zero-clear sequence (sampled in RUN only)
- REQ0_VALID  in  1  requester 0 has a write
- REQ0_READY  out  1  requester 0 write accepted this cycle
- REQ0_ADDR  in  AW  requester 0 destination register
- REQ0_DATA  in  DW  requester 0 write data
- REQ1_VALID / REQ1_READY / REQ1_ADDR / REQ1_DATA: same as requester 0, for requester 1
- WE3  out  1  register file write enable (registered)
- A3  out  AW  register file write address (registered)
- WD3  out  DW  register file write data (registered)
- BUSY  out  1  clear sequence in progress (registered)

## Operation
- States: INIT (clear) and RUN. Internal registers: cnt[AW-1:0] and prio (0 = requester 0 favoured).
- Reset (RST_N low, asynchronous): state=INIT, cnt=0, prio=0, WE3=0, A3=0, WD3=0, BUSY=1. REQx_READY=0 while in reset.
- INIT:
  - Each edge drives WE3=1, A3=cnt, WD3=0, then cnt+1.
  - On the edge that issues cnt=NREG-1: next state RUN, cnt=0.
  - REQ0_READY=REQ1_READY=0 throughout. CLR is ignored.
- RUN, combinational ready:
  - REQ0_READY = !CLR && (!REQ1_VALID || prio==0)
  - REQ1_READY = !CLR && (!REQ0_VALID || prio==1)
  - READY may be high with VALID low; no transfer then.
- Transfer on requester i when REQi_VALID && REQi_READY. At most one transfer per cycle.
- On transfer: next edge drives A3=REQi_ADDR, WD3=REQi_DATA, WE3=1. If DROP_ZERO=1 and the address is 0, WE3=0 but the handshake still completes. After any transfer to i, prio = the other requester.
- No transfer: WE3=0 next edge. A3/WD3 hold their last value.
- CLR=1 in RUN:
  - No transfer that cycle.
  - Next edge: state=INIT, cnt=0, BUSY=1, WE3=0.
  - Clear writes start on the following edge.
- Both requesters valid with the same address: arbitrated normally. The later-granted write lands one or more cycles later and wins.

## Timing
- Request-to-write latency: 1 cycle. Accepted in cycle N, WE3/A3/WD3 valid during cycle N+1; the register file captures them at the end of N+1.
- Post-reset clear:
  - First edge after RST_N rises issues A3=0.
  - WE3 stays high for exactly NREG consecutive cycles (A3 = 0..NREG-1).
  - BUSY falls on the same edge WE3 first drops.
  - First READY is possible in that cycle.
- CLR-triggered clear: 1 idle cycle (WE3=0, BUSY=1), then NREG clear writes.
- Reset asserted mid-clear or mid-RUN: outputs return to reset values immediately. An in-flight write is lost and the clear restarts from 0.
- Sustained throughput in RUN: 1 write per cycle. Under continuous contention, grants alternate strictly 0,1,0,1.

## Test plan
- Reset release, no requests:
  - WE3=1 for 32 cycles with A3=0..31, WD3=0.
  - Then WE3=0, BUSY 1->0 on that edge.
  - REQx_READY=0 throughout.
- Single requester in RUN: REQ0 addr=1, data=32'h5a5a5a5a for one cycle -> next cycle WE3=1, A3=1, WD3=32'h5a5a5a5a. Reading A1=1 afterwards gives RD1=32'h5a5a5a5a.
- Contention: both valid 4 cycles (REQ0 addr=2 data=32'h12345678, REQ1 addr=3 data=32'h87654321) -> grants 0,1,0,1. A3 sequence 2,3,2,3 on consecutive cycles.
- Zero register: REQ1 addr=0, data=32'hffffffff with DROP_ZERO=1 -> REQ1_READY=1, WE3 stays 0. RD of address 0 remains 0.
- CLR during RUN with REQ0 valid:
  - REQ0_READY=0 in the CLR cycle.
  - Then 1 idle cycle followed by a 32-cycle clear.
  - Registers 1..3 read 0 after BUSY falls.
  - REQ0 is then accepted.
- RST_N pulsed low while A3=15 during INIT -> WE3/A3/WD3 go to 0 asynchronously. After release the clear restarts at A3=0 and runs a full 32 cycles.

Source files
------------

// File: rtl/regfile_wp_sched.sv
// Write-port scheduler for the 32x32 register file: zero-clears all registers after reset/CLR, then round-robins two writeback requesters.
// Latency 1 cycle request-to-write; requesters are held off (ready low) during clear and in the CLR cycle.
module regfile_wp_sched #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int NREG      = 32,
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  logic [AW-1:0] req0_addr_i,
    input  logic [DW-1:0] req0_data_i,
    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    input  logic [AW-1:0] req1_addr_i,
    input  logic [DW-1:0] req1_data_i,
    output logic          we3_o,
    output logic [AW-1:0] a3_o,
    output logic [DW-1:0] wd3_o,
    output logic          busy_o
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          prio_q, prio_d;
    logic          we3_q, we3_d;
    logic [AW-1:0] a3_q, a3_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic          busy_q, busy_d;
    logic          rdy0, rdy1, xfer0, xfer1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            we3_q   <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            busy_q  <= busy_d;
        end
    end

    // Ready stays low while the last clear write is on the port (busy still high),
    // so WE3 is high for exactly NREG cycles and BUSY falls with it.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (state_q == RUN && !busy_q && !clr_i) begin
            rdy0 = !req1_valid_i || !prio_q;
            rdy1 = !req0_valid_i || prio_q;
        end
        xfer0 = req0_valid_i && rdy0;
        xfer1 = req1_valid_i && rdy1 && !xfer0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        we3_d   = 1'b0;
        a3_d    = a3_q;
        wd3_d   = wd3_q;
        busy_d  = busy_q;
        case (state_q)
            INIT: begin
                we3_d = 1'b1;
                a3_d  = cnt_q;
                wd3_d = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                busy_d = 1'b0;
                if (clr_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (xfer0) begin
                    a3_d   = req0_addr_i;
                    wd3_d  = req0_data_i;
                    we3_d  = !(DROP_ZERO && req0_addr_i == '0);
                    prio_d = 1'b1;
                end else if (xfer1) begin
                    a3_d   = req1_addr_i;
                    wd3_d  = req1_data_i;
                    we3_d  = !(DROP_ZERO && req1_addr_i == '0);
                    prio_d = 1'b0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign req0_ready_o = rdy0;
    assign req1_ready_o = rdy1;
    assign we3_o        = we3_q;
    assign a3_o         = a3_q;
    assign wd3_o        = wd3_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_regfile_wp_sched.sv
// Bench for regfile_wp_sched: vector table for RUN arbitration plus hand sequences for clear, CLR and reset.
module tb_regfile_wp_sched;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic          rdy0, rdy1;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          we3, busy;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;

    int checks = 0;
    int failures = 0;

    regfile_wp_sched #(.AW(AW), .DW(DW), .NREG(NREG), .DROP_ZERO(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
        .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_addr_i(a0), .req0_data_i(d0),
        .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_addr_i(a1), .req1_data_i(d1),
        .we3_o(we3), .a3_o(a3), .wd3_o(wd3), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Register file model fed by the write port
    logic [DW-1:0] rf [NREG];
    always @(posedge clk) if (we3) rf[a3] <= wd3;

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          r0;
        logic          r1;
        logic          we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd3;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd3;
    } exp_t;

    vec_t tbl[9];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Checks one full clear run; both requesters are kept valid to prove ready stays low.
    task automatic expect_clear();
        v0 = 1'b1; a0 = 5'd7; d0 = 32'h0000_0077;
        v1 = 1'b1; a1 = 5'd8; d1 = 32'h0000_0088;
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            chk("clr_we3", 64'(we3), 64'd1);
            chk("clr_a3", 64'(a3), 64'(i));
            chk("clr_wd3", 64'(wd3), 64'd0);
            chk("clr_busy", 64'(busy), 64'd1);
            chk("clr_rdy0", 64'(rdy0), 64'd0);
            chk("clr_rdy1", 64'(rdy1), 64'd0);
        end
        @(negedge clk);
        chk("clr_done_we3", 64'(we3), 64'd0);
        chk("clr_done_busy", 64'(busy), 64'd0);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        //           v0  a0  d0            v1  a1  d1            r0 r1 we a3  wd3
        tbl[0] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1, 1, 0, 5'd31, 32'h0};
        tbl[1] = '{1'b1, 5'd1, 32'h5a5a5a5a, 1'b0, 5'd0, 32'h0,        1, 0, 1, 5'd1,  32'h5a5a5a5a};
        tbl[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       0, 1, 1, 5'd4,  32'h44};
        tbl[3] = '{1'b1, 5'd2, 32'h12345678, 1'b1, 5'd3, 32'h87654321, 1, 0, 1, 5'd2,  32'h12345678};
        tbl[4] = '{1'b1, 5'd2, 32'h12345678, 1'b1, 5'd3, 32'h87654321, 0, 1, 1, 5'd3,  32'h87654321};
        tbl[5] = '{1'b1, 5'd2, 32'h12345678, 1'b1, 5'd3, 32'h87654321, 1, 0, 1, 5'd2,  32'h12345678};
        tbl[6] = '{1'b1, 5'd2, 32'h12345678, 1'b1, 5'd3, 32'h87654321, 0, 1, 1, 5'd3,  32'h87654321};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hffffffff, 1, 1, 0, 5'd0,  32'hffffffff};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1, 1, 0, 5'd0,  32'hffffffff};

        // Reset state, with requesters valid
        v0 = 1'b1; v1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_a3", 64'(a3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rdy0", 64'(rdy0), 64'd0);
        chk("rst_rdy1", 64'(rdy1), 64'd0);
        rst_n = 1'b1;
        expect_clear();

        // Table-driven arbitration in RUN
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("tbl_we3", 64'(we3), 64'(e.we));
                chk("tbl_a3", 64'(a3), 64'(e.a3));
                chk("tbl_wd3", 64'(wd3), 64'(e.wd3));
                chk("tbl_busy", 64'(busy), 64'd0);
            end
            v0 = tbl[k].v0; a0 = tbl[k].a0; d0 = tbl[k].d0;
            v1 = tbl[k].v1; a1 = tbl[k].a1; d1 = tbl[k].d1;
            #1;
            chk("tbl_rdy0", 64'(rdy0), 64'(tbl[k].r0));
            chk("tbl_rdy1", 64'(rdy1), 64'(tbl[k].r1));
            sbq.push_back('{tbl[k].we, tbl[k].a3, tbl[k].wd3});
        end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("tbl_we3", 64'(we3), 64'(e.we));
            chk("tbl_a3", 64'(a3), 64'(e.a3));
            chk("tbl_wd3", 64'(wd3), 64'(e.wd3));
        end
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        chk("rf1", 64'(rf[1]), 64'h5a5a5a5a);
        chk("rf2", 64'(rf[2]), 64'h12345678);
        chk("rf3", 64'(rf[3]), 64'h87654321);
        chk("rf4", 64'(rf[4]), 64'h44);
        chk("rf0", 64'(rf[0]), 64'h0);

        // CLR in RUN with requester 0 valid
        v0 = 1'b1; a0 = 5'd6; d0 = 32'h66; clr = 1'b1;
        #1;
        chk("clrcyc_rdy0", 64'(rdy0), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clridle_we3", 64'(we3), 64'd0);
        chk("clridle_busy", 64'(busy), 64'd1);
        chk("clridle_rdy0", 64'(rdy0), 64'd0);
        expect_clear();
        chk("clr_rf1", 64'(rf[1]), 64'h0);
        chk("clr_rf2", 64'(rf[2]), 64'h0);
        chk("clr_rf3", 64'(rf[3]), 64'h0);
        v0 = 1'b1; a0 = 5'd6; d0 = 32'h66;
        #1;
        chk("post_clr_rdy0", 64'(rdy0), 64'd1);
        @(negedge clk);
        v0 = 1'b0;
        chk("post_clr_we3", 64'(we3), 64'd1);
        chk("post_clr_a3", 64'(a3), 64'd6);
        chk("post_clr_wd3", 64'(wd3), 64'h66);

        // Reset pulsed mid-clear at A3=15
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (16) @(negedge clk);
        chk("mid_a3", 64'(a3), 64'd15);
        chk("mid_we3", 64'(we3), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we3", 64'(we3), 64'd0);
        chk("async_a3", 64'(a3), 64'd0);
        chk("async_wd3", 64'(wd3), 64'd0);
        chk("async_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        expect_clear();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
